// File: rtl/data_ram_responder.sv
// Data-side SRAM responder: word array with byte lanes, req/addr_ok/data_ok handshake, one request in flight.
// Latency: data_ok rises LATENCY cycles after acceptance (1..7); r_data/err are registered.
// Backpressure: addr_ok drops while a multi-cycle access waits; requests seen then are ignored.
// Optional alignment checking is enabled by defining DATA_RAM_ALIGN_CHECK_EN.
module data_ram_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_ram_req,
    input  logic        data_ram_wr,
    input  logic [1:0]  data_ram_size,
    input  logic [3:0]  data_ram_wstrb,
    input  logic [31:0] data_ram_addr,
    input  logic [31:0] data_ram_wdata,
    output logic        data_ram_addr_ok,
    output logic        data_ram_data_ok,
    output logic [31:0] data_ram_r_data,
    output logic        data_ram_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [1:0]        lo;
        logic [ADDR_W-1:0] idx;
    } req_t;

    localparam logic [2:0] CNT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    req_t        in_req, cur_req, src_req;
    logic        in_mis, src_mis;
    logic        accept, enter_resp;
    logic        unused_bits;
    logic [31:0] mem [2**ADDR_W];

    assign in_req.wr   = data_ram_wr;
    assign in_req.size = data_ram_size;
    assign in_req.lo   = data_ram_addr[1:0];
    assign in_req.idx  = data_ram_addr[ADDR_W+1:2];

    // With single-cycle latency the response is formed at the acceptance edge,
    // before the request has been latched, so it comes straight from the inputs.
    assign src_req = (accept && LATENCY == 1) ? in_req : cur_req;

`ifdef DATA_RAM_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'd1:    misaligned = lo[0];
            2'd2:    misaligned = (lo != 2'b00);
            2'd3:    misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    endfunction

    assign in_mis      = misaligned(in_req.size, in_req.lo);
    assign src_mis     = misaligned(src_req.size, src_req.lo);
    assign unused_bits = ^data_ram_addr[31:ADDR_W+2];
`else
    assign in_mis      = 1'b0;
    assign src_mis     = 1'b0;
    assign unused_bits = ^{data_ram_addr[31:ADDR_W+2], in_req.size, in_req.lo,
                           src_req.size, src_req.lo};
`endif

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        enter_resp       = 1'b0;
        data_ram_addr_ok = 1'b0;
        case (state)
            ST_IDLE: data_ram_addr_ok = 1'b1;
            ST_WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt  = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            ST_RESP: begin
                data_ram_addr_ok = 1'b1;
                state_nxt        = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (reset) begin
            data_ram_addr_ok = 1'b0;
        end
        accept = data_ram_req && data_ram_addr_ok;
        if (accept) begin
            if (LATENCY == 1) begin
                state_nxt  = ST_RESP;
                enter_resp = 1'b1;
            end else begin
                state_nxt = ST_WAIT;
                cnt_nxt   = CNT_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            cnt             <= 3'd0;
            data_ram_r_data <= 32'd0;
            data_ram_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (enter_resp) begin
                data_ram_err    <= src_mis;
                data_ram_r_data <= (src_req.wr || src_mis) ? 32'd0 : mem[src_req.idx];
            end
        end
    end

    // Storage is deliberately left out of reset so committed stores survive it.
    always_ff @(posedge clk) begin
        if (accept) begin
            cur_req <= in_req;
            if (in_req.wr && !in_mis) begin
                for (int i = 0; i < 4; i++) begin
                    if (data_ram_wstrb[i]) begin
                        mem[in_req.idx][8*i +: 8] <= data_ram_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    assign data_ram_data_ok = (state == ST_RESP);

endmodule
